switch_box_cfg_loader: RTL and testbench

- Serial configuration loader that sits directly upstream of switch_box_element_two and drives its 16-bit select bus c.
- Accepts a bit-serial configuration stream into a shadow shift register and validates each 2-bit select field.
- Commits the shadow to the live c bus atomically, so the switch box never sees a partially shifted word.
- Provides a scan-out bit so loaders can be daisy-chained across a tile row.

---
 rtl/switch_box_cfg_loader_if.sv | 23 ++
 rtl/switch_box_cfg_loader.sv | 125 ++++++++++++
 tb/tb_switch_box_cfg_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/switch_box_cfg_loader_if.sv
// rtl/switch_box_cfg_loader_if.sv - serial config stream and live select bus of the switch box loader
interface switch_box_cfg_loader_if #(
  parameter int CFG_WIDTH = 16
);
  logic                 cfg_bit_in;
  logic                 cfg_bit_valid;
  logic                 cfg_commit;
  logic                 cfg_bit_out;
  logic [CFG_WIDTH-1:0] c;
  logic                 cfg_loaded;
  logic                 cfg_error;
  logic                 busy;

  modport master (
    output cfg_bit_in, cfg_bit_valid, cfg_commit,
    input  cfg_bit_out, c, cfg_loaded, cfg_error, busy
  );

  modport slave (
    input  cfg_bit_in, cfg_bit_valid, cfg_commit,
    output cfg_bit_out, c, cfg_loaded, cfg_error, busy
  );
endinterface

// File: rtl/switch_box_cfg_loader.sv
// rtl/switch_box_cfg_loader.sv - serial shadow loader with atomic commit onto the switch box select bus
// Optional trailing even-parity bit per word: SWITCH_BOX_CFG_PARITY_EN
module switch_box_cfg_loader #(
  parameter int CFG_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  switch_box_cfg_loader_if.slave  cfg
);
  localparam int CW = $clog2(CFG_WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CFG_WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;
`ifdef SWITCH_BOX_CFG_PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd3;
  localparam logic [1:0] S_DONE   = S_PARITY;
`else
  localparam logic [1:0] S_DONE   = S_FULL;
`endif

  logic [1:0]           state_q, state_d;
  logic [CFG_WIDTH-1:0] shadow_q, shadow_d;
  logic [CFG_WIDTH-1:0] c_q, c_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 bit_out_q, bit_out_d;
  logic                 error_q, error_d;
  logic                 field_bad;
  logic                 word_ok;
  logic                 in_full;

  always_comb begin
    field_bad = 1'b0;
    for (int k = 0; k < CFG_WIDTH / 2; k++) begin
      field_bad = field_bad | (&shadow_q[2*k +: 2]);
    end
  end

`ifdef SWITCH_BOX_CFG_PARITY_EN
  logic parity_q, parity_d;
  assign word_ok = !field_bad && ((^shadow_q ^ parity_q) == 1'b0);
`else
  assign word_ok = !field_bad;
`endif

  assign in_full = (state_q == S_FULL);

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    c_d       = c_q;
    count_d   = count_q;
    bit_out_d = bit_out_q;
    error_d   = error_q;
`ifdef SWITCH_BOX_CFG_PARITY_EN
    parity_d  = parity_q;
`endif

    if (cfg.cfg_commit) begin
      if (in_full) begin
        state_d = S_IDLE;
        count_d = '0;
        if (word_ok) begin
          c_d     = shadow_q;
          error_d = 1'b0;
        end else begin
          error_d = 1'b1;
        end
      end else begin
        error_d = 1'b1;
      end
    end

    // A commit taken in FULL owns the cycle; the coincident bit is dropped.
    if (cfg.cfg_bit_valid && !(cfg.cfg_commit && in_full)) begin
`ifdef SWITCH_BOX_CFG_PARITY_EN
      if (state_q == S_PARITY) begin
        parity_d = cfg.cfg_bit_in;
        state_d  = S_FULL;
      end else
`endif
      begin
        shadow_d  = {shadow_q[CFG_WIDTH-2:0], cfg.cfg_bit_in};
        bit_out_d = shadow_q[CFG_WIDTH-1];
        if (count_q != CNT_FULL) begin
          count_d = count_q + 1'b1;
        end
        if (state_q != S_FULL) begin
          state_d = ((count_q + 1'b1) == CNT_FULL) ? S_DONE : S_SHIFT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shadow_q  <= '0;
      c_q       <= '0;
      count_q   <= '0;
      bit_out_q <= 1'b0;
      error_q   <= 1'b0;
`ifdef SWITCH_BOX_CFG_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      c_q       <= c_d;
      count_q   <= count_d;
      bit_out_q <= bit_out_d;
      error_q   <= error_d;
`ifdef SWITCH_BOX_CFG_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign cfg.c           = c_q;
  assign cfg.cfg_bit_out = bit_out_q;
  assign cfg.cfg_error   = error_q;
  assign cfg.cfg_loaded  = in_full;
  assign cfg.busy        = (state_q == S_SHIFT);
endmodule

// File: tb/tb_switch_box_cfg_loader.sv
// tb/tb_switch_box_cfg_loader.sv - randomized and directed bench for switch_box_cfg_loader
module tb_switch_box_cfg_loader;
  localparam int W = 16;
`ifdef SWITCH_BOX_CFG_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  switch_box_cfg_loader_if #(.CFG_WIDTH(W)) bus ();

  switch_box_cfg_loader #(.CFG_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .cfg (bus)
  );

  always #5 clk = ~clk;

  // Reference model: the last W accepted data bits, oldest first.
  bit          hist[$];
  int          nbits;
  bit          par_taken;
  bit          par_bit;
  logic [W-1:0] mc;
  bit          merr;
  bit          mout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] hist_word();
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) w[W-1-i] = hist[i];
    return w;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < W; i++) hist.push_back(1'b0);
    nbits = 0; par_taken = 0; par_bit = 0;
    mc = '0; merr = 0; mout = 0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit cm);
    bit full;
    bit legal;
    logic [W-1:0] word;
    full  = (nbits == W) && (!PAR || par_taken);
    word  = hist_word();
    legal = 1'b1;
    for (int k = 0; k < W / 2; k++) if (word[2*k +: 2] == 2'b11) legal = 1'b0;
    if (PAR && ((^word) ^ par_bit)) legal = 1'b0;
    if (cm) begin
      if (full) begin
        if (legal) begin mc = word; merr = 0; end
        else merr = 1;
        nbits = 0; par_taken = 0;
      end else begin
        merr = 1;
      end
    end
    if (v && !(cm && full)) begin
      if (PAR && nbits == W && !par_taken) begin
        par_bit = b; par_taken = 1;
      end else begin
        mout = hist[0];
        void'(hist.pop_front());
        hist.push_back(b);
        if (nbits < W) nbits++;
      end
    end
  endtask

  task automatic check_all();
    chk("c",        32'(bus.c),           32'(mc));
    chk("loaded",   32'(bus.cfg_loaded),  32'((nbits == W) && (!PAR || par_taken)));
    chk("error",    32'(bus.cfg_error),   32'(merr));
    chk("busy",     32'(bus.busy),        32'(nbits > 0 && nbits < W));
    chk("bit_out",  32'(bus.cfg_bit_out), 32'(mout));
  endtask

  task automatic cyc(input bit v, input bit b, input bit cm);
    bus.cfg_bit_valid = v;
    bus.cfg_bit_in    = b;
    bus.cfg_commit    = cm;
    @(posedge clk);
    model_step(v, b, cm);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cfg_bit_valid = 0; bus.cfg_bit_in = 0; bus.cfg_commit = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    rst = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] w, input bit bad_par);
    for (int i = W - 1; i >= 0; i--) cyc(1, w[i], 0);
    if (PAR) cyc(1, (^w) ^ bad_par, 0);
  endtask

  task automatic commit();
    cyc(0, 0, 1);
  endtask

  initial begin
    logic [W-1:0] w;
    bus.cfg_bit_valid = 0; bus.cfg_bit_in = 0; bus.cfg_commit = 0;
    model_reset();

    do_reset();
    chk("rst_c", 32'(bus.c), 32'h0);

    load(16'h1824, 0);
    chk("plan_loaded", 32'(bus.cfg_loaded), 32'h1);
    commit();
    chk("plan_c_1824", 32'(bus.c), 32'h1824);

    load(16'h0003, 0);
    commit();
    chk("plan_illegal_err", 32'(bus.cfg_error), 32'h1);
    chk("plan_illegal_c", 32'(bus.c), 32'h1824);
    load(16'h0000, 0);
    commit();
    chk("plan_zero_c", 32'(bus.c), 32'h0);
    chk("plan_zero_err", 32'(bus.cfg_error), 32'h0);

    w = 16'hA5A4;
    for (int i = W - 1; i >= 6; i--) cyc(1, w[i], 0);
    commit();
    chk("plan_premature_err", 32'(bus.cfg_error), 32'h1);
    chk("plan_premature_busy", 32'(bus.busy), 32'h1);
    for (int i = 5; i >= 0; i--) cyc(1, w[i], 0);
    if (PAR) cyc(1, ^w, 0);
    commit();
    chk("plan_a5a4_c", 32'(bus.c), 32'hA5A4);
    chk("plan_a5a4_err", 32'(bus.cfg_error), 32'h0);

    load(16'h1111, 0);
    load(16'h2222, 0);
    commit();
    chk("plan_chain_c", 32'(bus.c), 32'h2222);
    load(16'h1824, 0);
    cyc(1, 1, 1);
    chk("plan_drop_c", 32'(bus.c), 32'h1824);

    for (int i = 0; i < 8; i++) cyc(1, 1'($urandom), 0);
    do_reset();
    chk("plan_rst_c", 32'(bus.c), 32'h0);
    chk("plan_rst_busy", 32'(bus.busy), 32'h0);
    load(16'h4444, 0);
    commit();
    chk("plan_4444_c", 32'(bus.c), 32'h4444);
    if (PAR) begin
      load(16'h4444, 1);
      commit();
      chk("plan_badpar_err", 32'(bus.cfg_error), 32'h1);
      chk("plan_badpar_c", 32'(bus.c), 32'h4444);
    end

    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < W / 2; k++) w[2*k +: 2] = 2'($urandom_range(0, 2));
      load(w, ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 3)) cyc(0, 0, 0);
      commit();
    end

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc(($urandom_range(0, 9) < 6), 1'($urandom), ($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
